// File: rtl/ttl_pkg.sv
// rtl/ttl_pkg.sv - shared constants and helpers for the scanned TTL data selector
//
// Purpose : holds the select-mode encodings and a constant-evaluable clog2
//           used to size the select path of ttl_mux_scan and ttl_scan_ctr.
// Ports   : none (package).

package ttl_pkg;

    // Select source: manual select word or the internal scan counter.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2, usable in parameter expressions. Returns 0 for n <= 1,
    // so callers that need at least one select bit clamp the result.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ttl_scan_ctr.sv
// rtl/ttl_scan_ctr.sv - scan select counter with wrap pulse for ttl_mux_scan
//
// Purpose : steps through select values 0..INPUTS-1 on single-cycle step
//           ticks while in scan mode, and flags each wrap back to 0 with a
//           registered one-cycle pulse.
// Ports   :
//   i_clk       in   1      system clock, rising edge
//   i_rst_n     in   1      asynchronous active-low reset
//   i_mode      in   1      MODE_SCAN enables stepping; MODE_MANUAL holds
//   i_step      in   1      advance tick
//   i_sync_clr  in   1      synchronous clear, overrides step
//   o_cnt       out  SEL_W  current scan counter value
//   o_wrap      out  1      registered pulse, high the cycle after a wrap

module ttl_scan_ctr
    import ttl_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int SEL_W  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_sync_clr,
    output logic [SEL_W-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(INPUTS - 1);

    logic [SEL_W-1:0] r_cnt;
    logic             r_wrap;
    logic [SEL_W-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;

    // Clear beats step, so a simultaneous clear and step at the last value
    // returns to 0 without producing a wrap pulse.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (i_sync_clr) begin
            w_cnt_nxt = '0;
        end else if ((i_mode == MODE_SCAN) && i_step) begin
            if (r_cnt == LAST) begin
                w_cnt_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/ttl_mux_scan.sv
// rtl/ttl_mux_scan.sv - multi-group strobed data selector with scan counter
//
// Purpose : CHANNELS independent 1-of-INPUTS selectors of WIDTH-bit words with
//           a shared select, per-group active-low strobe, a combinational
//           output for drop-in use next to the TTL chip models, and a
//           registered copy for the display path. The select comes either
//           from sel or from an internal auto-stepping scan counter.
// Ports   :
//   clk       in   1                        system clock, rising edge
//   _rst      in   1                        asynchronous active-low reset
//   _stb      in   CHANNELS                 per-group strobe, high forces 0
//   mode      in   1                        0 manual (sel), 1 scan counter
//   sel       in   SEL_W                    manual select
//   step      in   1                        scan advance tick
//   sync_clr  in   1                        synchronous scan counter clear
//   d         in   CHANNELS*INPUTS*WIDTH    group g input i at
//                                           [(g*INPUTS+i)*WIDTH +: WIDTH]
//   y_comb    out  CHANNELS*WIDTH           combinational selected data
//   y         out  CHANNELS*WIDTH           y_comb registered, 1-cycle latency
//   cur_sel   out  SEL_W                    effective select in use
//   wrap      out  1                        pulse the cycle after a scan wrap

module ttl_mux_scan
    import ttl_pkg::*;
#(
    parameter  int CHANNELS = 2,
    parameter  int INPUTS   = 4,
    parameter  int WIDTH    = 1,
    localparam int SEL_W    = (clog2(INPUTS) > 1) ? clog2(INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         _rst,
    input  logic [CHANNELS-1:0]          _stb,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         step,
    input  logic                         sync_clr,
    input  logic [CHANNELS*INPUTS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0]    y_comb,
    output logic [CHANNELS*WIDTH-1:0]    y,
    output logic [SEL_W-1:0]             cur_sel,
    output logic                         wrap
);

    logic [SEL_W-1:0]          w_cnt;
    logic                      w_wrap;
    logic [SEL_W-1:0]          w_eff;
    logic [CHANNELS*WIDTH-1:0] w_y_comb;
    logic [CHANNELS*WIDTH-1:0] r_y;

    ttl_scan_ctr #(
        .INPUTS (INPUTS),
        .SEL_W  (SEL_W)
    ) u_scan_ctr (
        .i_clk      (clk),
        .i_rst_n    (_rst),
        .i_mode     (mode),
        .i_step     (step),
        .i_sync_clr (sync_clr),
        .o_cnt      (w_cnt),
        .o_wrap     (w_wrap)
    );

    assign w_eff = (mode == MODE_SCAN) ? w_cnt : sel;

    // Decoded select rather than an indexed part-select: when INPUTS is not
    // a power of two, select codes >= INPUTS match no input and the group
    // reads 0 instead of X or a neighbouring group's data.
    always_comb begin
        w_y_comb = '0;
        for (int g = 0; g < CHANNELS; g++) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (!_stb[g] && (w_eff == SEL_W'(i))) begin
                    w_y_comb[g*WIDTH +: WIDTH] = d[(g*INPUTS+i)*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_y_comb;
        end
    end

    assign y_comb  = w_y_comb;
    assign y       = r_y;
    assign cur_sel = w_eff;
    assign wrap    = w_wrap;

endmodule

// File: tb/tb_ttl_mux_scan.sv
// tb/tb_ttl_mux_scan.sv - self-checking bench for ttl_mux_scan

module tb_ttl_mux_scan;

    logic clk;
    logic rst_n;

    // Instance A: CHANNELS=2, INPUTS=4, WIDTH=1 (LS153 equivalent)
    logic [1:0]  a_stb;
    logic        a_mode;
    logic [1:0]  a_sel;
    logic        a_step;
    logic        a_clr;
    logic [7:0]  a_d;
    logic [1:0]  a_yc;
    logic [1:0]  a_y;
    logic [1:0]  a_cur;
    logic        a_wrap;

    // Instance B: CHANNELS=2, INPUTS=3, WIDTH=8
    logic [1:0]  b_stb;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic        b_step;
    logic        b_clr;
    logic [47:0] b_d;
    logic [15:0] b_yc;
    logic [15:0] b_y;
    logic [1:0]  b_cur;
    logic        b_wrap;

    int n_checks;
    int n_errors;

    logic [1:0] ma_cnt;
    logic [1:0] mb_cnt;

    logic [1:0]  q_ay[$];
    logic [15:0] q_by[$];
    logic        q_aw[$];
    logic        q_bw[$];

    ttl_mux_scan #(.CHANNELS(2), .INPUTS(4), .WIDTH(1)) dut_a (
        .clk      (clk),
        ._rst     (rst_n),
        ._stb     (a_stb),
        .mode     (a_mode),
        .sel      (a_sel),
        .step     (a_step),
        .sync_clr (a_clr),
        .d        (a_d),
        .y_comb   (a_yc),
        .y        (a_y),
        .cur_sel  (a_cur),
        .wrap     (a_wrap)
    );

    ttl_mux_scan #(.CHANNELS(2), .INPUTS(3), .WIDTH(8)) dut_b (
        .clk      (clk),
        ._rst     (rst_n),
        ._stb     (b_stb),
        .mode     (b_mode),
        .sel      (b_sel),
        .step     (b_step),
        .sync_clr (b_clr),
        .d        (b_d),
        .y_comb   (b_yc),
        .y        (b_y),
        .cur_sel  (b_cur),
        .wrap     (b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model_a(input logic [7:0] d, input logic [1:0] s,
                                           input logic [1:0] stb);
        logic [1:0] r;
        r = '0;
        for (int g = 0; g < 2; g++) begin
            if (!stb[g]) r[g] = d[g*4 + int'(s)];
        end
        return r;
    endfunction

    function automatic logic [15:0] model_b(input logic [47:0] d, input logic [1:0] s,
                                            input logic [1:0] stb);
        logic [15:0] r;
        r = '0;
        for (int g = 0; g < 2; g++) begin
            if (!stb[g] && (int'(s) < 3)) r[g*8 +: 8] = d[(g*3 + int'(s))*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [2:0] next_ctr(input logic [1:0] cnt, input logic mode,
                                            input logic step, input logic clr,
                                            input logic [1:0] last);
        if (clr) return 3'b000;
        if (mode && step) begin
            if (cnt == last) return 3'b100;
            return {1'b0, cnt + 2'd1};
        end
        return {1'b0, cnt};
    endfunction

    // One clock cycle: check combinational outputs against the model,
    // queue the expected registered values, clock, then pop and compare.
    // Returns at posedge+1 so callers can drive the next inputs.
    task automatic tick();
        logic [1:0] ea;
        logic [1:0] eb;
        logic [2:0] na;
        logic [2:0] nb;
        logic [1:0]  ey_a;
        logic [15:0] ey_b;
        logic        ew;
        #1;
        ea = a_mode ? ma_cnt : a_sel;
        eb = b_mode ? mb_cnt : b_sel;
        n_checks++;
        if (a_cur !== ea) begin
            n_errors++;
            $display("FAIL a_cur_sel t=%0t got=%0d exp=%0d", $time, a_cur, ea);
        end
        n_checks++;
        if (b_cur !== eb) begin
            n_errors++;
            $display("FAIL b_cur_sel t=%0t got=%0d exp=%0d", $time, b_cur, eb);
        end
        n_checks++;
        if (a_yc !== model_a(a_d, ea, a_stb)) begin
            n_errors++;
            $display("FAIL a_y_comb t=%0t got=%b exp=%b", $time, a_yc, model_a(a_d, ea, a_stb));
        end
        n_checks++;
        if (b_yc !== model_b(b_d, eb, b_stb)) begin
            n_errors++;
            $display("FAIL b_y_comb t=%0t got=%h exp=%h", $time, b_yc, model_b(b_d, eb, b_stb));
        end
        q_ay.push_back(model_a(a_d, ea, a_stb));
        q_by.push_back(model_b(b_d, eb, b_stb));
        na = next_ctr(ma_cnt, a_mode, a_step, a_clr, 2'd3);
        nb = next_ctr(mb_cnt, b_mode, b_step, b_clr, 2'd2);
        q_aw.push_back(na[2]);
        q_bw.push_back(nb[2]);
        @(posedge clk);
        ma_cnt = na[1:0];
        mb_cnt = nb[1:0];
        #1;
        ey_a = q_ay.pop_front();
        n_checks++;
        if (a_y !== ey_a) begin
            n_errors++;
            $display("FAIL a_y t=%0t got=%b exp=%b", $time, a_y, ey_a);
        end
        ey_b = q_by.pop_front();
        n_checks++;
        if (b_y !== ey_b) begin
            n_errors++;
            $display("FAIL b_y t=%0t got=%h exp=%h", $time, b_y, ey_b);
        end
        ew = q_aw.pop_front();
        n_checks++;
        if (a_wrap !== ew) begin
            n_errors++;
            $display("FAIL a_wrap t=%0t got=%b exp=%b", $time, a_wrap, ew);
        end
        ew = q_bw.pop_front();
        n_checks++;
        if (b_wrap !== ew) begin
            n_errors++;
            $display("FAIL b_wrap t=%0t got=%b exp=%b", $time, b_wrap, ew);
        end
    endtask

    task automatic test_reset_initial();
        #2;
        n_checks++;
        if (a_y !== 2'b00 || b_y !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_y got a=%b b=%h exp=0", a_y, b_y);
        end
        n_checks++;
        if (a_wrap !== 1'b0 || b_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wrap got a=%b b=%b exp=0", a_wrap, b_wrap);
        end
        n_checks++;
        if (b_cur !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_cur_sel got=%0d exp=0", b_cur);
        end
        #1;
        rst_n = 1'b1;
        ma_cnt = 2'd0;
        mb_cnt = 2'd0;
    endtask

    task automatic test_manual_ls153();
        logic [1:0] tbl [4];
        tbl[0] = 2'b10; tbl[1] = 2'b01; tbl[2] = 2'b10; tbl[3] = 2'b01;
        a_mode = 1'b0;
        a_stb  = 2'b00;
        a_d    = 8'b0101_1010;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            #1;
            n_checks++;
            if (a_yc !== tbl[s]) begin
                n_errors++;
                $display("FAIL ls153_sel%0d got=%b exp=%b", s, a_yc, tbl[s]);
            end
            tick();
        end
    endtask

    task automatic test_strobe();
        a_mode = 1'b0;
        a_d    = 8'hFF;
        a_sel  = 2'd1;
        a_stb  = 2'b01;
        #1;
        n_checks++;
        if (a_yc !== 2'b10) begin
            n_errors++;
            $display("FAIL strobe_g0 got=%b exp=10", a_yc);
        end
        tick();
        a_stb = 2'b10;
        #1;
        n_checks++;
        if (a_yc !== 2'b01) begin
            n_errors++;
            $display("FAIL strobe_g1 got=%b exp=01", a_yc);
        end
        tick();
        a_stb = 2'b00;
    endtask

    task automatic test_scan();
        logic [1:0] seq [5];
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0; seq[4] = 2'd1;
        b_d    = 48'h665544_332211;
        b_stb  = 2'b00;
        b_mode = 1'b1;
        b_step = 1'b0;
        b_clr  = 1'b1;
        tick();
        b_clr  = 1'b0;
        b_step = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (b_cur !== seq[k]) begin
                n_errors++;
                $display("FAIL scan_seq%0d got=%0d exp=%0d", k, b_cur, seq[k]);
            end
            n_checks++;
            if (b_wrap !== (k == 3)) begin
                n_errors++;
                $display("FAIL scan_wrap%0d got=%b exp=%b", k, b_wrap, (k == 3));
            end
            tick();
        end
        b_step = 1'b0;
    endtask

    task automatic test_clr_step();
        b_mode = 1'b1;
        b_clr  = 1'b1;
        tick();
        b_clr  = 1'b0;
        b_step = 1'b1;
        tick();
        tick();
        b_clr = 1'b1;
        #1;
        n_checks++;
        if (b_cur !== 2'd2) begin
            n_errors++;
            $display("FAIL clr_pre got=%0d exp=2", b_cur);
        end
        tick();
        b_clr  = 1'b0;
        b_step = 1'b0;
        #1;
        n_checks++;
        if (b_cur !== 2'd0 || b_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_step got cnt=%0d wrap=%b exp cnt=0 wrap=0", b_cur, b_wrap);
        end
        b_step = 1'b1;
        tick();
        b_mode = 1'b0;
        b_sel  = 2'd2;
        tick();
        tick();
        b_mode = 1'b1;
        b_step = 1'b0;
        #1;
        n_checks++;
        if (b_cur !== 2'd1) begin
            n_errors++;
            $display("FAIL manual_hold got=%0d exp=1", b_cur);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        b_mode = 1'b0;
        b_sel  = 2'd3;
        b_stb  = 2'b00;
        b_d    = 48'hFFFFFF_FFFFFF;
        #1;
        n_checks++;
        if (b_yc !== 16'h0) begin
            n_errors++;
            $display("FAIL oor_comb got=%h exp=0000", b_yc);
        end
        tick();
        n_checks++;
        if (b_y !== 16'h0) begin
            n_errors++;
            $display("FAIL oor_reg got=%h exp=0000", b_y);
        end
    endtask

    task automatic test_reset_mid();
        b_mode = 1'b1;
        b_stb  = 2'b00;
        b_d    = 48'hA5A5A5_5A5A5A;
        b_clr  = 1'b0;
        b_step = 1'b1;
        tick();
        b_step = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (b_cur !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_cur got=%0d exp=0", b_cur);
        end
        n_checks++;
        if (b_y !== 16'h0 || a_y !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_mid_y got a=%b b=%h exp=0", a_y, b_y);
        end
        n_checks++;
        if (b_wrap !== 1'b0 || a_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_wrap got a=%b b=%b exp=0", a_wrap, b_wrap);
        end
        rst_n  = 1'b1;
        ma_cnt = 2'd0;
        mb_cnt = 2'd0;
        b_step = 1'b1;
        tick();
        b_step = 1'b0;
        #1;
        n_checks++;
        if (b_cur !== 2'd1) begin
            n_errors++;
            $display("FAIL rst_resume got=%0d exp=1", b_cur);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            a_d    = 8'($urandom);
            a_sel  = 2'($urandom_range(0, 3));
            a_stb  = 2'($urandom_range(0, 3));
            a_mode = 1'($urandom_range(0, 1));
            a_step = 1'($urandom_range(0, 1));
            a_clr  = ($urandom_range(0, 15) == 0);
            b_d    = 48'({$urandom, $urandom});
            b_sel  = 2'($urandom_range(0, 3));
            b_stb  = 2'($urandom_range(0, 3));
            b_mode = 1'($urandom_range(0, 1));
            b_step = 1'($urandom_range(0, 1));
            b_clr  = ($urandom_range(0, 15) == 0);
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        ma_cnt = 2'd0;
        mb_cnt = 2'd0;
        a_stb = 2'b00; a_mode = 1'b0; a_sel = 2'd0; a_step = 1'b0; a_clr = 1'b0; a_d = '0;
        b_stb = 2'b00; b_mode = 1'b1; b_sel = 2'd0; b_step = 1'b0; b_clr = 1'b0; b_d = '0;
        test_reset_initial();
        test_manual_ls153();
        test_strobe();
        test_scan();
        test_clr_step();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
